// File: rtl/bufgctrl_switch_ctrl_pkg.sv
// Shared types and reset constants for the BUFGCTRL source-switch sequencer.
package bufgctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OFF_WAIT,
        SEL,
        ON_WAIT,
        DONE
    } state_t;

    // Power-up pin state: I0 selected and enabled, I1 parked.
    localparam logic CE0_RST     = 1'b1;
    localparam logic CE1_RST     = 1'b0;
    localparam logic S0_RST      = 1'b1;
    localparam logic S1_RST      = 1'b0;
    localparam logic CUR_SEL_RST = 1'b0;

endpackage

// File: rtl/bufgctrl_switch_ctrl_if.sv
// Request/status handshake between a switch requester and the BUFGCTRL sequencer.
interface bufgctrl_switch_ctrl_if;

    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic done;
    logic busy;
    logic cur_sel;

    modport master (
        output req_valid,
        output req_sel,
        input  req_ready,
        input  done,
        input  busy,
        input  cur_sel
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        output req_ready,
        output done,
        output busy,
        output cur_sel
    );

endinterface

// File: rtl/bufgctrl_switch_ctrl_settle_timer.sv
// Down-counter that holds the sequencer in a wait state for a fixed number of cycles.
module settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Saturates at zero so a stale count never wraps while the FSM is idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bufgctrl_switch_ctrl.sv
// Glitch-free BUFGCTRL source switch: disable old CE, settle, swap selects,
// enable new CE, settle, then report completion.
module bufgctrl_switch_ctrl
    import bufgctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    bufgctrl_switch_ctrl_if.slave bus,
    output logic                  ce0,
    output logic                  ce1,
    output logic                  s0,
    output logic                  s1,
    output logic                  ignore0,
    output logic                  ignore1
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t state, state_nxt;
    logic   target, target_nxt;
    logic   cur_q, cur_nxt;
    logic   ce0_q, ce0_nxt;
    logic   ce1_q, ce1_nxt;
    logic   s0_q, s0_nxt;
    logic   s1_q, s1_nxt;
    logic   ready_q, ready_nxt;
    logic   busy_q, busy_nxt;
    logic   done_q, done_nxt;
    logic   timer_load;
    logic   timer_zero;

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .load   (timer_load),
        .value  (RELOAD),
        .zero   (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            target  <= CUR_SEL_RST;
            cur_q   <= CUR_SEL_RST;
            ce0_q   <= CE0_RST;
            ce1_q   <= CE1_RST;
            s0_q    <= S0_RST;
            s1_q    <= S1_RST;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            target  <= target_nxt;
            cur_q   <= cur_nxt;
            ce0_q   <= ce0_nxt;
            ce1_q   <= ce1_nxt;
            s0_q    <= s0_nxt;
            s1_q    <= s1_nxt;
            ready_q <= ready_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    // Status flags are derived from the next state so they stay registered
    // yet line up with the state they describe.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        cur_nxt    = cur_q;
        ce0_nxt    = ce0_q;
        ce1_nxt    = ce1_q;
        s0_nxt     = s0_q;
        s1_nxt     = s1_q;
        timer_load = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    if (bus.req_sel == cur_q) begin
                        state_nxt = DONE;
                    end else begin
                        target_nxt = bus.req_sel;
                        state_nxt  = OFF_WAIT;
                        timer_load = 1'b1;
                        if (cur_q) ce1_nxt = 1'b0;
                        else       ce0_nxt = 1'b0;
                    end
                end
            end
            OFF_WAIT: begin
                if (timer_zero) begin
                    state_nxt = SEL;
                    s0_nxt    = ~target;
                    s1_nxt    = target;
                end
            end
            SEL: begin
                state_nxt  = ON_WAIT;
                timer_load = 1'b1;
                if (target) ce1_nxt = 1'b1;
                else        ce0_nxt = 1'b1;
            end
            ON_WAIT: begin
                if (timer_zero) begin
                    cur_nxt   = target;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
    end

    assign ce0           = ce0_q;
    assign ce1           = ce1_q;
    assign s0            = s0_q;
    assign s1            = s1_q;
    assign ignore0       = 1'b0;
    assign ignore1       = 1'b0;
    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cur_sel   = cur_q;

    // Both inputs enabled, or both/neither selected, would let the buffer glitch.
    ce_exclusive: assert property (@(posedge clk) disable iff (!resetn) !(ce0_q && ce1_q));
    s_exclusive:  assert property (@(posedge clk) disable iff (!resetn) (s0_q != s1_q));

endmodule

// File: tb/tb_bufgctrl_switch_ctrl.sv
// Self-checking bench: one instance with SETTLE_CYCLES=8 (index 0) and one with 1 (index 1).
module tb_bufgctrl_switch_ctrl;

    typedef struct packed {
        logic ce0;
        logic ce1;
        logic s0;
        logic s1;
        logic cur_sel;
        logic req_ready;
        logic busy;
        logic done;
        logic ignore0;
        logic ignore1;
    } pins_t;

    typedef struct {
        bit    rstn;
        bit    v;
        bit    sel;
        pins_t exp;
    } vec_t;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] ce0_w, ce1_w, s0_w, s1_w, ig0_w, ig1_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bufgctrl_switch_ctrl_if bus8 ();
    bufgctrl_switch_ctrl_if bus1 ();

    bufgctrl_switch_ctrl #(.SETTLE_CYCLES(8), .CNT_W(8)) dut8 (
        .clk (clk), .resetn (resetn), .bus (bus8),
        .ce0 (ce0_w[0]), .ce1 (ce1_w[0]), .s0 (s0_w[0]), .s1 (s1_w[0]),
        .ignore0 (ig0_w[0]), .ignore1 (ig1_w[0])
    );

    bufgctrl_switch_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk (clk), .resetn (resetn), .bus (bus1),
        .ce0 (ce0_w[1]), .ce1 (ce1_w[1]), .s0 (s0_w[1]), .s1 (s1_w[1]),
        .ignore0 (ig0_w[1]), .ignore1 (ig1_w[1])
    );

    function automatic pins_t observe(int i);
        pins_t p;
        p.ce0     = ce0_w[i];
        p.ce1     = ce1_w[i];
        p.s0      = s0_w[i];
        p.s1      = s1_w[i];
        p.ignore0 = ig0_w[i];
        p.ignore1 = ig1_w[i];
        if (i == 0) begin
            p.cur_sel = bus8.cur_sel; p.req_ready = bus8.req_ready;
            p.busy    = bus8.busy;    p.done      = bus8.done;
        end else begin
            p.cur_sel = bus1.cur_sel; p.req_ready = bus1.req_ready;
            p.busy    = bus1.busy;    p.done      = bus1.done;
        end
        return p;
    endfunction

    function automatic pins_t idle_pins(bit cur);
        pins_t p;
        p.ce0 = ~cur; p.ce1 = cur; p.s0 = ~cur; p.s1 = cur;
        p.cur_sel = cur; p.req_ready = 1'b1; p.busy = 1'b0; p.done = 1'b0;
        p.ignore0 = 1'b0; p.ignore1 = 1'b0;
        return p;
    endfunction

    // Expected pins k cycles after acceptance, straight from the timing table.
    function automatic pins_t during(bit from, bit to, int n, int k);
        pins_t p;
        bit    ce_new, s_flip;
        if (from == to) begin
            p = idle_pins(from);
            p.req_ready = 1'b0; p.busy = 1'b1; p.done = 1'b1;
            return p;
        end
        ce_new = (k >= n + 1);
        s_flip = (k >= n);
        p.ce0 = to ? 1'b0 : ce_new;
        p.ce1 = to ? ce_new : 1'b0;
        p.s0  = to ? ~s_flip : s_flip;
        p.s1  = to ? s_flip : ~s_flip;
        p.done      = (k == 2 * n + 1);
        p.cur_sel   = p.done ? to : from;
        p.req_ready = 1'b0;
        p.busy      = 1'b1;
        p.ignore0   = 1'b0;
        p.ignore1   = 1'b0;
        return p;
    endfunction

    task automatic checkOutput(string name, pins_t got, pins_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got ce0/ce1/s0/s1/cur/rdy/busy/done/ig0/ig1=%b required %b",
                     name, got, exp);
        end
    endtask

    task automatic checkValue(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus(int i, bit v, bit sel);
        if (i == 0) begin
            bus8.req_valid = v; bus8.req_sel = sel;
        end else begin
            bus1.req_valid = v; bus1.req_sel = sel;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    function automatic vec_t mk(bit rstn, bit v, bit sel, logic [9:0] e);
        vec_t r;
        r.rstn = rstn; r.v = v; r.sel = sel; r.exp = pins_t'(e);
        return r;
    endfunction

    vec_t vecs[14];

    // Behavioural model state for the random phase
    bit m_act[2], m_cur[2], m_from[2], m_to[2], m_prev_ready[2];
    int m_k[2];
    int nset[2] = '{8, 1};

    initial begin
        int   fall_k, flip_k, rise_k, done_k, done_cnt, first_done, second_done;
        bit   rv[2], rs[2], rst;
        pins_t p, e;

        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);

        // ---- Test 1: reset then idle ----
        doReset();
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("reset_idle", observe(0), idle_pins(1'b0));
        end

        // ---- Table: 0->1, same-source, 1->0 with ignored requests (N=1) ----
        //                      ce0 ce1 s0 s1 cur rdy busy done ig0 ig1
        vecs[0]  = mk(0, 0, 0, 10'b1_0_1_0_0_1_0_0_0_0);
        vecs[1]  = mk(1, 0, 0, 10'b1_0_1_0_0_1_0_0_0_0);
        vecs[2]  = mk(1, 1, 1, 10'b0_0_1_0_0_0_1_0_0_0);
        vecs[3]  = mk(1, 0, 0, 10'b0_0_0_1_0_0_1_0_0_0);
        vecs[4]  = mk(1, 0, 0, 10'b0_1_0_1_0_0_1_0_0_0);
        vecs[5]  = mk(1, 0, 0, 10'b0_1_0_1_1_0_1_1_0_0);
        vecs[6]  = mk(1, 0, 0, 10'b0_1_0_1_1_1_0_0_0_0);
        vecs[7]  = mk(1, 1, 1, 10'b0_1_0_1_1_0_1_1_0_0);
        vecs[8]  = mk(1, 0, 0, 10'b0_1_0_1_1_1_0_0_0_0);
        vecs[9]  = mk(1, 1, 0, 10'b0_0_0_1_1_0_1_0_0_0);
        vecs[10] = mk(1, 1, 1, 10'b0_0_1_0_1_0_1_0_0_0);
        vecs[11] = mk(1, 1, 1, 10'b1_0_1_0_1_0_1_0_0_0);
        vecs[12] = mk(1, 0, 0, 10'b1_0_1_0_0_0_1_1_0_0);
        vecs[13] = mk(1, 0, 0, 10'b1_0_1_0_0_1_0_0_0_0);
        for (int r = 0; r < 14; r++) begin
            resetn = vecs[r].rstn;
            applyStimulus(1, vecs[r].v, vecs[r].sel);
            tick();
            checkOutput($sformatf("table_row%0d", r), observe(1), vecs[r].exp);
        end
        applyStimulus(1, 1'b0, 1'b0);
        resetn = 1'b1;

        // ---- Test 2 + 4: N=8 switch 0->1 with a stray request mid-switch ----
        fall_k = -1; flip_k = -1; rise_k = -1; done_k = -1; done_cnt = 0;
        applyStimulus(0, 1'b1, 1'b1);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 0) applyStimulus(0, 1'b0, 1'b0);
            if (k == 4) applyStimulus(0, 1'b1, 1'b0);
            if (k == 5) applyStimulus(0, 1'b0, 1'b0);
            p = observe(0);
            if (fall_k < 0 && !p.ce0) fall_k = k + 1;
            if (flip_k < 0 && p.s1 && !p.s0) flip_k = k + 1;
            if (rise_k < 0 && p.ce1) rise_k = k + 1;
            if (p.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k + 1;
            end
        end
        checkValue("n8_ce0_fall", fall_k, 1);
        checkValue("n8_sel_flip", flip_k, 9);
        checkValue("n8_ce1_rise", rise_k, 10);
        checkValue("n8_done_time", done_k, 18);
        checkValue("n8_done_count", done_cnt, 1);
        checkOutput("n8_final", observe(0), idle_pins(1'b1));

        // ---- Test 3: same-source request ----
        doReset();
        tick();
        applyStimulus(0, 1'b1, 1'b0);
        tick();
        e = idle_pins(1'b0);
        e.req_ready = 1'b0; e.busy = 1'b1; e.done = 1'b1;
        checkOutput("same_src_done", observe(0), e);
        applyStimulus(0, 1'b0, 1'b0);
        tick();
        checkOutput("same_src_after", observe(0), idle_pins(1'b0));

        // ---- Test 5: reset during ON_WAIT ----
        applyStimulus(0, 1'b1, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) tick();
        checkOutput("on_wait_reached", observe(0), during(1'b0, 1'b1, 8, 12));
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checkOutput("reset_in_on_wait", observe(0), idle_pins(1'b0));

        // ---- Test 6: N=1 back-to-back with req_valid held ----
        first_done = -1; second_done = -1;
        applyStimulus(1, 1'b1, 1'b1);
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus1.done) begin
                if (first_done < 0) begin
                    first_done = k;
                    checkValue("b2b_cur_after_first", bus1.cur_sel, 1);
                    applyStimulus(1, 1'b1, 1'b0);
                end else if (second_done < 0) begin
                    second_done = k;
                    checkValue("b2b_cur_after_second", bus1.cur_sel, 0);
                    applyStimulus(1, 1'b0, 1'b0);
                end
            end
        end
        applyStimulus(1, 1'b0, 1'b0);
        checkValue("b2b_first_seen", (first_done >= 0) ? 1 : 0, 1);
        checkValue("b2b_gap", second_done - first_done, 5);

        // ---- Random phase against the transaction-level model ----
        for (int c = 0; c < 1500; c++) begin
            rst = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            for (int i = 0; i < 2; i++) begin
                rv[i] = ($urandom_range(0, 2) == 0);
                rs[i] = 1'($urandom_range(0, 1));
                applyStimulus(i, rv[i], rs[i]);
            end
            resetn = rst;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!rst) begin
                    m_act[i] = 1'b0;
                    m_cur[i] = 1'b0;
                end else begin
                    if (m_act[i]) begin
                        m_k[i]++;
                        if (m_k[i] > ((m_from[i] == m_to[i]) ? 0 : 2 * nset[i] + 1)) begin
                            m_act[i] = 1'b0;
                            m_cur[i] = m_to[i];
                        end
                    end
                    if (!m_act[i] && m_prev_ready[i] && rv[i]) begin
                        m_act[i]  = 1'b1;
                        m_k[i]    = 0;
                        m_from[i] = m_cur[i];
                        m_to[i]   = rs[i];
                    end
                end
                e = m_act[i] ? during(m_from[i], m_to[i], nset[i], m_k[i]) : idle_pins(m_cur[i]);
                m_prev_ready[i] = e.req_ready;
                checkOutput($sformatf("random_n%0d_cyc%0d", nset[i], c), observe(i), e);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
